// File: rtl/mux4x1_pkg.sv
// Shared constants for the registered 4:1 select tree.
package mux4x1_pkg;
  localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/mux4x1_mux2x1.sv
// Combinational 2:1 word select: y = sel ? b : a.
module mux2x1
  import mux4x1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux4x1.sv
// Registered 4:1 multiplexer built from a two-level tree of 2:1 muxes.
// s0 steers the first level, s1 the second; output register has a sync active-low clear.
module mux4x1
  import mux4x1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] lvl1_a [2];
  logic [WIDTH-1:0] lvl1_b [2];
  logic [WIDTH-1:0] lvl1_y [2];
  logic [WIDTH-1:0] y_nxt;
  logic [WIDTH-1:0] y_reg;

  // Slot 0 forms m_lo (i0/i1), slot 1 forms m_hi (i2/i3).
  assign lvl1_a[0] = i0;
  assign lvl1_b[0] = i1;
  assign lvl1_a[1] = i2;
  assign lvl1_b[1] = i3;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lvl1
      mux2x1 #(.WIDTH(WIDTH)) u_mux (
        .a   (lvl1_a[gi]),
        .b   (lvl1_b[gi]),
        .sel (s0),
        .y   (lvl1_y[gi])
      );
    end
  endgenerate

  mux2x1 #(.WIDTH(WIDTH)) u_lvl2 (
    .a   (lvl1_y[0]),
    .b   (lvl1_y[1]),
    .sel (s1),
    .y   (y_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_reg <= '0;
    end else begin
      y_reg <= y_nxt;
    end
  end

  assign y = y_reg;

endmodule

// File: tb/tb_mux4x1.sv
// Self-checking bench for mux4x1 at WIDTH=4 and WIDTH=8 against an indexed-array reference.
module tb_mux4x1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s0, s1;
  logic [3:0] a0, a1, a2, a3, y4;
  logic [7:0] b0, b1, b2, b3, y8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux4x1 #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i0(a0), .i1(a1), .i2(a2), .i3(a3),
    .s0(s0), .s1(s1), .y(y4)
  );

  mux4x1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i0(b0), .i1(b1), .i2(b2), .i3(b3),
    .s0(s0), .s1(s1), .y(y8)
  );

  // Reference: the select value is simply an index into the list of inputs.
  function automatic logic [3:0] ref4(input logic [1:0] sel);
    logic [3:0] d [4];
    d[0] = a0; d[1] = a1; d[2] = a2; d[3] = a3;
    return d[sel];
  endfunction

  function automatic logic [7:0] ref8(input logic [1:0] sel);
    logic [7:0] d [4];
    d[0] = b0; d[1] = b1; d[2] = b2; d[3] = b3;
    return d[sel];
  endfunction

  task automatic check4(input string tag, input logic [3:0] exp);
    checks++;
    assert (y4 === exp) else begin
      errors++;
      $error("FAIL %s: y=%h expected %h", tag, y4, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] exp);
    checks++;
    assert (y8 === exp) else begin
      errors++;
      $error("FAIL %s: y=%h expected %h", tag, y8, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [1:0] sel);
    s1 = sel[1];
    s0 = sel[0];
  endtask

  initial begin
    logic [3:0]  e4;
    logic [7:0]  e8;
    logic [1:0]  sel;
    logic        rst_now;
    logic [1:0]  sweep [4];

    rst_n = 1'b0;
    a0 = 4'd9; a1 = 4'd12; a2 = 4'd4; a3 = 4'd10;
    b0 = 8'hA5; b1 = 8'h3C; b2 = 8'hFF; b3 = 8'h00;
    set_sel(2'b00);

    // T1: reset held for two edges, then release with sel=00
    tick(); check4("t1_rst_edge1", 4'd0); check8("t1_rst8_edge1", 8'h00);
    tick(); check4("t1_rst_edge2", 4'd0); check8("t1_rst8_edge2", 8'h00);
    rst_n = 1'b1;
    tick(); check4("t1_release", 4'd9);
    $display("T1 reset/release y4=%0d", y4);

    // T2: select sweep in the order 00,10,01,11
    sweep[0] = 2'b00; sweep[1] = 2'b10; sweep[2] = 2'b01; sweep[3] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      set_sel(sweep[k]);
      e4 = ref4(sweep[k]);
      tick();
      check4("t2_sweep", e4);
      $display("T2 sel=%b y4=%0d exp=%0d", sweep[k], y4, e4);
    end
    if (e4 !== 4'd10) begin
      errors++;
      $error("FAIL t2_ref_sanity: model=%0d expected 10", e4);
    end
    checks++;

    // T3: mid-cycle select change must not reach y before the edge
    set_sel(2'b00);
    tick(); check4("t3_pre", 4'd9);
    #2 set_sel(2'b11);
    #1 check4("t3_hold", 4'd9);
    tick(); check4("t3_after", 4'd10);
    $display("T3 latency y4=%0d", y4);

    // T4: data tracking on i2, other inputs are don't-care
    set_sel(2'b10);
    a2 = 4'd15;
    tick(); check4("t4_track", 4'd15);
    a0 = 4'd1; a1 = 4'd2; a3 = 4'd3;
    #1 check4("t4_midcycle", 4'd15);
    tick(); check4("t4_undisturbed", 4'd15);
    $display("T4 tracking y4=%0d", y4);

    // T5: reset in mid-operation
    a0 = 4'd9; a1 = 4'd12; a2 = 4'd4; a3 = 4'd10;
    set_sel(2'b11);
    tick(); check4("t5_pre", 4'd10);
    rst_n = 1'b0;
    tick(); check4("t5_rst", 4'd0); check8("t5_rst8", 8'h00);
    rst_n = 1'b1;
    tick(); check4("t5_release", 4'd10);
    $display("T5 mid-op reset y4=%0d", y4);

    // T6: 8-bit sweep, bit-exact
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      set_sel(sel);
      e8 = ref8(sel);
      tick();
      check8("t6_width8", e8);
      $display("T6 sel=%b y8=%h exp=%h", sel, y8, e8);
    end

    // Random: data, selects and occasional reset, both widths
    for (int n = 0; n < 200; n++) begin
      a0 = 4'($urandom); a1 = 4'($urandom); a2 = 4'($urandom); a3 = 4'($urandom);
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      sel = 2'($urandom_range(0, 3));
      rst_now = ($urandom_range(0, 15) == 0);
      set_sel(sel);
      rst_n = ~rst_now;
      e4 = rst_now ? 4'd0 : ref4(sel);
      e8 = rst_now ? 8'd0 : ref8(sel);
      tick();
      check4("rand_w4", e4);
      check8("rand_w8", e8);
      $display("R%0d rst=%b sel=%b y4=%h/%h y8=%h/%h", n, rst_now, sel, y4, e4, y8, e8);
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
